// File: rtl/stim_sequencer.sv
// stim_sequencer: table-driven stimulus player with per-step masked result check.
//
// Replays a programmable table of DIP/push-button vectors into the processor
// Wrapper. Each vector is held for a per-step dwell count. At the end of the
// dwell, the Wrapper result is sampled and checked against a masked
// expectation. Pass/fail status and a saturating mismatch count are exposed.
//
// Optional feature macro: STIM_SEQ_LOOP_EN
//   defined   -> after the final step, restart at step 0 automatically; a START
//                pulse while running ends the loop after the next completed pass.
//   undefined -> single-shot; START while busy is ignored.
//
// Ports
//   CLK       in   clock, rising edge
//   RESET     in   asynchronous active-low reset
//   LD_EN     in   table write strobe (ignored while BUSY)
//   LD_ADDR   in   table entry index
//   LD_DIP    in   entry DIP vector
//   LD_PB     in   entry push-button vector
//   LD_DWELL  in   entry dwell in cycles (0 behaves as 1)
//   LD_EXP    in   entry expected result
//   LD_MASK   in   entry compare mask (1 = bit checked)
//   LAST      in   index of final step, latched on START
//   START     in   begin a run (honoured only when idle)
//   RESULT    in   observed Wrapper result
//   DIP       out  registered DIP stimulus
//   PB        out  registered push-button stimulus
//   BUSY      out  run in progress
//   DONE      out  one-cycle pulse after the final check
//   PASS      out  last run had no mismatches
//   MISMATCH  out  one-cycle pulse on a failed check
//   FAIL_CNT  out  saturating mismatch count of the current/last run
//   STEP_IDX  out  step currently applied
module stim_sequencer #(
  parameter int unsigned N_DIPs  = 16,
  parameter int unsigned N_PBs   = 3,
  parameter int unsigned N_STEPS = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned RES_W   = 32,
  localparam int unsigned AW     = $clog2(N_STEPS),
  localparam int unsigned FCW    = AW + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LD_EN,
  input  logic [AW-1:0]      LD_ADDR,
  input  logic [N_DIPs-1:0]  LD_DIP,
  input  logic [N_PBs-1:0]   LD_PB,
  input  logic [DWELL_W-1:0] LD_DWELL,
  input  logic [RES_W-1:0]   LD_EXP,
  input  logic [RES_W-1:0]   LD_MASK,
  input  logic [AW-1:0]      LAST,
  input  logic               START,
  input  logic [RES_W-1:0]   RESULT,
  output logic [N_DIPs-1:0]  DIP,
  output logic [N_PBs-1:0]   PB,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic               MISMATCH,
  output logic [FCW-1:0]     FAIL_CNT,
  output logic [AW-1:0]      STEP_IDX
);

  // One table entry
  typedef struct packed {
    logic [N_DIPs-1:0]  dip;
    logic [N_PBs-1:0]   pb;
    logic [DWELL_W-1:0] dwell;
    logic [RES_W-1:0]   exp_val;
    logic [RES_W-1:0]   mask;
  } entry_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_DWELL = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  entry_t             tbl [N_STEPS];
  entry_t             cur;

  logic [2:0]         state_q,  state_d;
  logic [N_DIPs-1:0]  dip_q,    dip_d;
  logic [N_PBs-1:0]   pb_q,     pb_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               pass_q,   pass_d;
  logic               mis_q,    mis_d;
  logic [FCW-1:0]     fail_q,   fail_d;
  logic [AW-1:0]      step_q,   step_d;
  logic [AW-1:0]      last_q,   last_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
`ifdef STIM_SEQ_LOOP_EN
  logic               stop_q,   stop_d;
`endif

  // Table write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (LD_EN && !busy_q) begin
      tbl[LD_ADDR] <= '{dip: LD_DIP, pb: LD_PB, dwell: LD_DWELL,
                        exp_val: LD_EXP, mask: LD_MASK};
    end
  end

  assign cur = tbl[step_q];

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      dip_q   <= '0;
      pb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= 1'b0;
      fail_q  <= '0;
      step_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
`ifdef STIM_SEQ_LOOP_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dip_q   <= dip_d;
      pb_q    <= pb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef STIM_SEQ_LOOP_EN
      stop_q  <= stop_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    dip_d   = dip_q;
    pb_d    = pb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mis_d   = 1'b0;
    fail_d  = fail_q;
    step_d  = step_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef STIM_SEQ_LOOP_EN
    stop_d  = stop_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The DONE cycle is already idle; a START there is dropped
        if (START && !done_q) begin
          state_d = S_APPLY;
          busy_d  = 1'b1;
          last_d  = LAST;
          step_d  = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
`ifdef STIM_SEQ_LOOP_EN
          stop_d  = 1'b0;
`endif
        end
      end

      S_APPLY: begin
        dip_d   = cur.dip;
        pb_d    = cur.pb;
        cnt_d   = (cur.dwell == '0) ? DWELL_W'(1) : cur.dwell;
        state_d = S_DWELL;
      end

      S_DWELL: begin
        // Counter loaded with d gives exactly d cycles here
        if (cnt_q <= DWELL_W'(1)) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      S_CHECK: begin
        if ((RESULT & cur.mask) != (cur.exp_val & cur.mask)) begin
          mis_d = 1'b1;
          if (fail_q != '1) begin
            fail_d = fail_q + FCW'(1);
          end
        end
        if (step_q == last_q) begin
          state_d = S_FIN;
        end else begin
          step_d  = step_q + AW'(1);
          state_d = S_APPLY;
        end
      end

      S_FIN: begin
        done_d = 1'b1;
        pass_d = (fail_q == '0);
`ifdef STIM_SEQ_LOOP_EN
        if (stop_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
        end else begin
          state_d = S_APPLY;
          step_d  = '0;
          fail_d  = '0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef STIM_SEQ_LOOP_EN
    // A START while looping requests exit at the next completed pass
    if (START && busy_q && !done_q && (state_q != S_FIN)) begin
      stop_d = 1'b1;
    end
`endif
  end

  assign DIP      = dip_q;
  assign PB       = pb_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign MISMATCH = mis_q;
  assign FAIL_CNT = fail_q;
  assign STEP_IDX = step_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Testbench for stim_sequencer: timeline-based reference model plus directed
// and randomized runs.
module tb_stim_sequencer;

  localparam int unsigned N_DIPs  = 16;
  localparam int unsigned N_PBs   = 3;
  localparam int unsigned N_STEPS = 8;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned RES_W   = 32;
  localparam int unsigned AW      = 3;
  localparam int unsigned FCW     = 4;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               LD_EN = 1'b0;
  logic [AW-1:0]      LD_ADDR = '0;
  logic [N_DIPs-1:0]  LD_DIP = '0;
  logic [N_PBs-1:0]   LD_PB = '0;
  logic [DWELL_W-1:0] LD_DWELL = '0;
  logic [RES_W-1:0]   LD_EXP = '0;
  logic [RES_W-1:0]   LD_MASK = '0;
  logic [AW-1:0]      LAST = '0;
  logic               START = 1'b0;
  logic [RES_W-1:0]   RESULT = '0;
  logic [N_DIPs-1:0]  DIP;
  logic [N_PBs-1:0]   PB;
  logic               BUSY, DONE, PASS, MISMATCH;
  logic [FCW-1:0]     FAIL_CNT;
  logic [AW-1:0]      STEP_IDX;

  always #5 CLK = ~CLK;

  stim_sequencer dut (
    .CLK(CLK), .RESET(RESET), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR),
    .LD_DIP(LD_DIP), .LD_PB(LD_PB), .LD_DWELL(LD_DWELL), .LD_EXP(LD_EXP),
    .LD_MASK(LD_MASK), .LAST(LAST), .START(START), .RESULT(RESULT),
    .DIP(DIP), .PB(PB), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .MISMATCH(MISMATCH), .FAIL_CNT(FAIL_CNT), .STEP_IDX(STEP_IDX)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run started at edge t0: step k occupies edges [off_k, off_k+len_k) with
  // off_0 = t0+1, len_k = max(dwell_k,1)+2; first edge is the apply, last the check.
  // The edge after the final step is the finish edge.
  logic [N_DIPs-1:0] m_dip  [N_STEPS];
  logic [N_PBs-1:0]  m_pb   [N_STEPS];
  int                m_dw   [N_STEPS];
  logic [RES_W-1:0]  m_exp  [N_STEPS];
  logic [RES_W-1:0]  m_mask [N_STEPS];
  bit     m_run = 0;
  longint m_t0 = 0;
  int     m_last = 0;
  longint cyc = 0;

  logic [N_DIPs-1:0] exp_dip = '0;
  logic [N_PBs-1:0]  exp_pb = '0;
  bit exp_busy = 0, exp_done = 0, exp_pass = 0, exp_mis = 0;
  int exp_fail = 0, exp_step = 0;

  initial begin
    for (int i = 0; i < N_STEPS; i++) begin
      m_dip[i] = '0; m_pb[i] = '0; m_dw[i] = 1; m_exp[i] = '0; m_mask[i] = '0;
    end
  end

  always @(posedge CLK) begin : model
    int rel, off, len, p;
    bit found, prev_done, prev_busy;
    cyc = cyc + 1;
    if (!RESET) begin
      m_run = 0; exp_dip = '0; exp_pb = '0; exp_busy = 0; exp_done = 0;
      exp_pass = 0; exp_mis = 0; exp_fail = 0; exp_step = 0;
    end else begin
      prev_done = exp_done;
      prev_busy = exp_busy;
      exp_done = 0;
      exp_mis = 0;
      if (LD_EN && !prev_busy) begin
        m_dip[LD_ADDR] = LD_DIP; m_pb[LD_ADDR] = LD_PB;
        m_dw[LD_ADDR] = (LD_DWELL == 0) ? 1 : int'(LD_DWELL);
        m_exp[LD_ADDR] = LD_EXP; m_mask[LD_ADDR] = LD_MASK;
      end
      if (m_run) begin
        rel = int'(cyc - m_t0);
        off = 1;
        found = 0;
        for (int k = 0; k <= m_last; k++) begin
          len = m_dw[k] + 2;
          if (!found && rel < off + len) begin
            found = 1;
            p = rel - off;
            if (p == 0) begin
              exp_dip = m_dip[k];
              exp_pb = m_pb[k];
            end
            if (p == len - 1) begin
              if (((RESULT ^ m_exp[k]) & m_mask[k]) != 0) begin
                exp_mis = 1;
                if (exp_fail < 15) exp_fail++;
              end
              if (k < m_last) exp_step = k + 1;
            end
          end
          off += len;
        end
        if (!found) begin
          exp_done = 1;
          exp_pass = (exp_fail == 0);
          exp_busy = 0;
          m_run = 0;
        end
      end else if (START && !prev_done) begin
        m_run = 1; m_t0 = cyc; m_last = int'(LAST);
        exp_busy = 1; exp_step = 0; exp_fail = 0; exp_pass = 0;
      end
    end
  end

  // Compare every cycle, shortly after the active edge
  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      chk("dip", DIP, exp_dip);
      chk("pb", PB, exp_pb);
      chk("busy", BUSY, exp_busy);
      chk("done", DONE, exp_done);
      chk("pass", PASS, exp_pass);
      chk("mismatch", MISMATCH, exp_mis);
      chk("fail_cnt", FAIL_CNT, exp_fail);
      chk("step_idx", STEP_IDX, exp_step);
    end
  end

  // ---------------- Wrapper result source ----------------
  // 0: matches the current step; 1: as 0 but forced value on one step;
  // 2: random mix of matches and garbage; 3: constant
  int res_mode = 0;
  int force_step = 0;
  logic [RES_W-1:0] force_val = '0;

  always @(negedge CLK) begin
    logic [RES_W-1:0] good;
    good = (m_exp[exp_step] & m_mask[exp_step]) | ($urandom & ~m_mask[exp_step]);
    case (res_mode)
      0: RESULT = good;
      1: RESULT = (exp_step == force_step) ? force_val : good;
      2: RESULT = ($urandom_range(0, 2) != 0) ? good : $urandom;
      default: RESULT = force_val;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int a, input logic [N_DIPs-1:0] d, input logic [N_PBs-1:0] pbv,
                      input int dw, input logic [RES_W-1:0] e, input logic [RES_W-1:0] m);
    @(negedge CLK);
    LD_EN = 1; LD_ADDR = AW'(a); LD_DIP = d; LD_PB = pbv;
    LD_DWELL = DWELL_W'(dw); LD_EXP = e; LD_MASK = m;
    @(posedge CLK);
    #1 LD_EN = 0;
  endtask

  // Returns cycles from the START edge to the first cycle DONE is high
  task automatic run(input int last, input int max_cyc, output int n, output int mis_cnt);
    bit seen;
    @(negedge CLK);
    LAST = AW'(last);
    START = 1;
    @(posedge CLK);
    #1 START = 0;
    n = 0; mis_cnt = 0; seen = 0;
    while (n < max_cyc && !seen) begin
      @(posedge CLK);
      #1;
      n++;
      if (MISMATCH === 1'b1) mis_cnt++;
      if (DONE === 1'b1) seen = 1;
    end
    chk("run_done_seen", seen, 1);
    repeat (2) @(negedge CLK);
  endtask

  int n, mc, exp_n, last_r;
  bit seen_done;

  initial begin
    // Reset held with clock running
    repeat (3) @(negedge CLK);
    chk_en = 1;
    @(negedge CLK);
    chk("rst_dip", DIP, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_fail_cnt", FAIL_CNT, 0);
    chk("rst_step", STEP_IDX, 0);
    RESET = 1;
    repeat (2) @(negedge CLK);

    // Single step, dwell 0 behaves as 1
    load(0, 16'h1234, 3'd5, 0, 32'h0, 32'h0);
    run(0, 50, n, mc);
    chk("lat_one_step", n, 4);
    chk("one_step_pass", PASS, 1);
    chk("one_step_dip", DIP, 16'h1234);

    // Three-step all-match
    load(0, 16'h0000, 3'd0, 30, 32'h60, 32'hFFFF_FFFF);
    load(1, 16'h05DB, 3'd1, 30, 32'h40, 32'hFFFF_FFFF);
    load(2, 16'hA188, 3'd2, 30, 32'hE0, 32'hFFFF_FFFF);
    res_mode = 0;
    run(2, 200, n, mc);
    chk("lat_three_step", n, 97);
    chk("three_pass", PASS, 1);
    chk("three_fail_cnt", FAIL_CNT, 0);
    chk("three_mis_pulses", mc, 0);
    chk("three_last_dip", DIP, 16'hA188);

    // Forced mismatch on step 1
    res_mode = 1; force_step = 1; force_val = 32'h41;
    run(2, 200, n, mc);
    chk("mis_latency", n, 97);
    chk("mis_pulses", mc, 1);
    chk("mis_fail_cnt", FAIL_CNT, 1);
    chk("mis_pass", PASS, 0);

    // Masked compare: only bits [7:4] checked
    load(0, 16'h00F0, 3'd3, 5, 32'h60, 32'h0000_00F0);
    res_mode = 3; force_val = 32'h6F;
    run(0, 50, n, mc);
    chk("mask_latency", n, 8);
    chk("mask_pass", PASS, 1);
    chk("mask_pulses", mc, 0);

    // Writes and START while busy are ignored
    res_mode = 0;
    load(0, 16'h0F0F, 3'd1, 10, 32'h0, 32'h0);
    load(1, 16'hF0F0, 3'd2, 10, 32'h0, 32'h0);
    fork
      run(1, 100, n, mc);
      begin
        repeat (6) @(negedge CLK);
        LD_EN = 1; LD_ADDR = '0; LD_DIP = 16'hFFFF; LD_DWELL = 16'd1; START = 1;
        @(negedge CLK);
        LD_EN = 0; START = 0;
      end
    join
    chk("guard_latency", n, 25);
    run(0, 50, n, mc);
    chk("guard_latency_rerun", n, 13);
    chk("guard_table_kept", DIP, 16'h0F0F);

    // Reset mid-dwell aborts with no DONE
    load(0, 16'hBEEF, 3'd7, 40, 32'h0, 32'h0);
    @(negedge CLK);
    LAST = '0; START = 1;
    @(posedge CLK);
    #1 START = 0;
    repeat (10) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("abort_dip", DIP, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_pb", PB, 0);
    @(negedge CLK);
    RESET = 1;
    seen_done = 0;
    repeat (60) begin
      @(posedge CLK);
      #1;
      if (DONE === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);

    // Randomized tables, lengths and results
    res_mode = 2;
    for (int it = 0; it < 8; it++) begin
      int dws [N_STEPS];
      for (int a = 0; a < N_STEPS; a++) begin
        dws[a] = $urandom_range(0, 6);
        load(a, N_DIPs'($urandom), N_PBs'($urandom), dws[a], $urandom,
             ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      end
      last_r = $urandom_range(0, N_STEPS - 1);
      exp_n = 1;
      for (int a = 0; a <= last_r; a++) exp_n += ((dws[a] == 0) ? 1 : dws[a]) + 2;
      run(last_r, 200, n, mc);
      chk("rand_latency", n, exp_n);
    end

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Synthesizable, parametrised successor to the fixed-delay DIP bench stimulus. It replays a programmable table of switch and push-button vectors into the processor Wrapper inputs, holding each vector for a per-step dwell count. At the end of each dwell it samples the Wrapper's SEVENSEGHEX result and compares it against a per-step masked expected value. Pass/fail status and a mismatch count are exposed, so the same check runs in simulation and on the board.

## Interface
- N_DIPs, 16, width of driven DIP vector
- N_PBs, 3, width of driven push-button vector
- N_STEPS, 8, table depth (power of two, 2..64)
- DWELL_W, 16, dwell counter width (cycles)
- RES_W, 32, width of sampled result
- CLK  in  1  single clock, rising-edge
- RESET  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- LD_EN  in  1  write table entry this cycle (honoured only when BUSY=0)
- LD_ADDR  in  log2(N_STEPS)  entry index
- LD_DIP  in  N_DIPs  entry DIP vector
- LD_PB  in  N_PBs  entry PB vector
- LD_DWELL  in  DWELL_W  entry dwell; 0 treated as 1
- LD_EXP  in  RES_W  entry expected result
- LD_MASK  in  RES_W  entry compare mask (1 = bit checked)
- LAST  in  log2(N_STEPS)  index of final step, sampled on START
- START  in  1  begin run (honoured only in IDLE)
- RESULT  in  RES_W  observed Wrapper result (SEVENSEGHEX)
- DIP  out  N_DIPs  registered stimulus to Wrapper
- PB  out  N_PBs  registered stimulus to Wrapper
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse after final check
- PASS  out  1  last run had zero mismatches; valid when DONE has been seen
- MISMATCH  out  1  one-cycle pulse on a failed check
- FAIL_CNT  out  log2(N_STEPS)+1  mismatches in current/last run
- STEP_IDX  out  log2(N_STEPS)  step currently applied

## Operation
- States: IDLE, APPLY, DWELL, CHECK, FIN.
- IDLE: if START, latch LAST, set STEP_IDX=0, clear FAIL_CNT and PASS, go to APPLY.
- APPLY (1 cycle): register DIP/PB from entry STEP_IDX; load dwell counter with max(LD_DWELL entry, 1); go to DWELL.
- DWELL: decrement the counter each cycle; on reaching 1, go to CHECK.
- CHECK (1 cycle): compare (RESULT & MASK) against (EXP & MASK). On inequality, pulse MISMATCH and increment FAIL_CNT, saturating at all-ones.
  - If STEP_IDX==LAST, go to FIN.
  - Otherwise increment STEP_IDX and go to APPLY.
- FIN (1 cycle): pulse DONE, set PASS=(FAIL_CNT==0), go to IDLE.
- BUSY=1 in every state except IDLE.
- DIP/PB hold their last applied vector after the run; they are not cleared in IDLE.
- Table writes: synchronous, one entry per cycle. LD_EN while BUSY=1 is ignored; the table is never modified mid-run.
- START while BUSY=1 is ignored.
- LAST greater than or equal to N_STEPS is impossible by width; LAST=0 runs exactly one step.
- The table is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: DIP=0, PB=0, BUSY=0, DONE=0, PASS=0, MISMATCH=0, FAIL_CNT=0, STEP_IDX=0, state IDLE.
- RESET assertion mid-run aborts immediately to the reset values, with no DONE pulse.
- START seen at edge t: BUSY=1 from t+1; DIP valid from t+2.
- Each step occupies dwell+2 cycles (APPLY + dwell + CHECK).
- RESULT is sampled at the CHECK edge, dwell+1 cycles after DIP changes.
- DONE pulses exactly 1 cycle after the final CHECK; BUSY=0 in the same cycle that DONE is high (back in IDLE the cycle after).
- A total run with uniform dwell d and L=LAST+1 steps takes L*(d+2)+1 cycles from START to DONE.
- A START asserted in the same cycle as DONE is ignored.

## Configuration
- STIM_SEQ_LOOP_EN defined: after FIN, the block restarts at step 0 automatically instead of returning to IDLE. FAIL_CNT is then cleared and DONE still pulses once per pass. A START pulse while running stops the loop after the current FIN, after which the block returns to IDLE.
- STIM_SEQ_LOOP_EN undefined: single-shot as described above, and START while BUSY is ignored.

## Test plan
- Reset: hold RESET=0 with the clock running → all outputs at reset values; release, START with no writes and LAST=0 → DONE after 1*(1+2)+1=4 cycles.
- Three-step match: load DIP 0x0000/0x05DB/0xA188, dwell 30, EXP 0x60/0x40/0xE0, MASK 0xFFFFFFFF, RESULT model matching → DIP sequence correct, PASS=1, FAIL_CNT=0, DONE at cycle 97 after START.
- Mismatch: same table, force RESULT=0x41 during step 1 → single MISMATCH pulse at step 1 CHECK, FAIL_CNT=1, PASS=0.
- Mask/dwell edge: MASK=0x000000F0, EXP=0x60, RESULT=0x6F → pass; dwell entry 0 → treated as 1 cycle (3-cycle step).
- Guarding: LD_EN and START pulsed while BUSY → table unchanged and run not restarted; RESET low mid-DWELL → outputs return to reset values, no DONE pulse.
- Loop (STIM_SEQ_LOOP_EN): two-step table → DONE pulses every 2*(d+2)+1 cycles, FAIL_CNT cleared each pass; START → returns to IDLE after next FIN.
